// File: rtl/fpu_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fpu_rr_arbiter
// Brief    : Round-robin sharing of one FPU between two valid/ready clients.
//            Optional WAIT timeout enabled by defining FPU_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_rr_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_data,
    output logic        fpu_enable,
    output logic [1:0]  fpu_instruction,
    output logic [31:0] fpu_ai,
    output logic [31:0] fpu_bi,
    input  logic [31:0] fpu_co,
    input  logic        fpu_valid,
    output logic        busy,
    output logic        timeout_err
);

    localparam logic [31:0] c_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_last_grant;
    logic        r_owner;
    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_rsp0_data;
    logic [31:0] r_rsp1_data;
    logic        w_winner;
    logic        w_grant;
    logic        w_timeout;
    logic        w_terr;
    logic        w_done;
    logic        w_hold;
    logic [31:0] w_result;

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
        $error("TIMEOUT_CYCLES must be >= 1");
    end

`ifdef FPU_ARB_TIMEOUT_EN
    localparam int c_CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [c_CNT_W-1:0] r_wait_cnt;
    logic               r_timeout_err;

    // fpu_valid on the final count cycle wins over the timeout
    assign w_timeout = (r_state == WAIT) && !fpu_valid &&
                       (r_wait_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == WAIT) begin
                r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign w_terr = r_timeout_err;
`else
    assign w_timeout = 1'b0;
    assign w_terr    = 1'b0;
`endif

    // On a tie the requester that was not granted last wins
    always_comb begin
        w_winner = req1_valid;
        if (req0_valid && req1_valid) begin
            w_winner = ~r_last_grant;
        end
    end

    assign w_grant  = (r_state == IDLE) && (req0_valid || req1_valid) && !w_terr;
    assign w_done   = (r_state == WAIT) && (fpu_valid || w_timeout);
    assign w_result = fpu_valid ? fpu_co : c_QNAN;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_grant) w_state_next = ISSUE;
            ISSUE:   w_state_next = WAIT;
            WAIT:    if (w_done) w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_rsp0_data  <= '0;
            r_rsp1_data  <= '0;
        end else begin
            if (w_grant) begin
                r_owner      <= w_winner;
                r_last_grant <= w_winner;
                r_op         <= w_winner ? req1_op : req0_op;
                r_a          <= w_winner ? req1_a  : req0_a;
                r_b          <= w_winner ? req1_b  : req0_b;
            end
            if (w_done) begin
                if (r_owner) begin
                    r_rsp1_data <= w_result;
                end else begin
                    r_rsp0_data <= w_result;
                end
            end
        end
    end

    assign w_hold          = (r_state == ISSUE) || (r_state == WAIT);
    assign req0_ready      = w_grant && !w_winner;
    assign req1_ready      = w_grant && w_winner;
    assign fpu_enable      = (r_state == ISSUE);
    assign fpu_instruction = w_hold ? r_op : 2'b00;
    assign fpu_ai          = w_hold ? r_a  : 32'h0;
    assign fpu_bi          = w_hold ? r_b  : 32'h0;
    assign rsp0_valid      = (r_state == RESP) && !r_owner;
    assign rsp1_valid      = (r_state == RESP) && r_owner;
    assign rsp0_data       = r_rsp0_data;
    assign rsp1_data       = r_rsp1_data;
    assign busy            = (r_state != IDLE);
    assign timeout_err     = w_terr;

endmodule
`default_nettype wire

// File: tb/tb_fpu_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_rr_arbiter
// Brief    : Randomized scoreboard bench for fpu_rr_arbiter with an FPU model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_rr_arbiter;

    localparam int          c_TO    = 8;
    localparam int          c_NEVER = 32'h7FFF_FFFF;
    localparam logic [31:0] c_QNAN  = 32'h7FC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [1:0]  req0_op, req1_op, fpu_instruction;
    logic [31:0] req0_a, req0_b, req1_a, req1_b, rsp0_data, rsp1_data;
    logic        rsp0_valid, rsp1_valid, fpu_enable, fpu_valid, busy, timeout_err;
    logic [31:0] fpu_ai, fpu_bi, fpu_co;

    always #5 clk = ~clk;

    fpu_rr_arbiter #(.TIMEOUT_CYCLES(c_TO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .fpu_enable(fpu_enable), .fpu_instruction(fpu_instruction),
        .fpu_ai(fpu_ai), .fpu_bi(fpu_bi), .fpu_co(fpu_co), .fpu_valid(fpu_valid),
        .busy(busy), .timeout_err(timeout_err)
    );

    typedef struct {int cyc; logic [1:0] op; logic [31:0] a; logic [31:0] b;} issue_t;
    typedef struct {int cyc; int owner; logic [31:0] data;} rsp_t;

    issue_t      iss_q[$];
    rsp_t        rsp_q[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;

    // Requester state and reference-model state (schedule in absolute cycles)
    bit          p_v[2];
    logic [1:0]  p_op[2];
    logic [31:0] p_a[2], p_b[2];
    bit          en_mask[2];
    bit          spur_en, timeout_mode;
    int          m_last, m_free, m_wait_lo, m_wait_hi, m_hold_lo, m_hold_hi;
    int          m_fv_cyc, m_terr_cyc;
    logic [31:0] m_fv_co, m_a, m_b, last0, last1;
    logic [1:0]  m_op;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_msg(input string msg);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", msg, cyc);
    endtask

    task automatic model_reset();
        m_last = 1; m_free = 0; m_fv_cyc = -1; m_terr_cyc = c_NEVER;
        m_wait_lo = -10; m_wait_hi = -10; m_hold_lo = -10; m_hold_hi = -10;
        last0 = '0; last1 = '0;
        p_v[0] = 0; p_v[1] = 0;
        iss_q.delete(); rsp_q.delete();
    endtask

    // One clock cycle: drive inputs, decide the grant, check combinational view.
    task automatic step(input bit hold);
        int          w, d;
        logic [31:0] co;
        bit          idle;
        logic        exp0, exp1;
        @(negedge clk);
        if (!hold) begin
            for (int i = 0; i < 2; i++) begin
                if (!p_v[i]) begin
                    if (en_mask[i] && $urandom_range(1, 0) == 1) begin
                        p_v[i]  = 1;
                        p_op[i] = 2'($urandom_range(3, 0));
                        p_a[i]  = $urandom;
                        p_b[i]  = $urandom;
                    end
                end else if ($urandom_range(7, 0) == 0) begin
                    p_v[i] = 0;
                end
            end
        end
        req0_valid = p_v[0]; req0_op = p_op[0]; req0_a = p_a[0]; req0_b = p_b[0];
        req1_valid = p_v[1]; req1_op = p_op[1]; req1_a = p_a[1]; req1_b = p_b[1];
        if (cyc == m_fv_cyc) begin
            fpu_valid = 1'b1;
            fpu_co    = m_fv_co;
        end else if (spur_en && (cyc < m_wait_lo || cyc > m_wait_hi) && $urandom_range(3, 0) == 0) begin
            fpu_valid = 1'b1;
            fpu_co    = $urandom;
        end else begin
            fpu_valid = 1'b0;
            fpu_co    = $urandom;
        end
        #1;
        idle = (cyc >= m_free);
        exp0 = 1'b0;
        exp1 = 1'b0;
        if (idle && (p_v[0] || p_v[1]) && cyc < m_terr_cyc) begin
            w  = (p_v[0] && p_v[1]) ? 1 - m_last : (p_v[1] ? 1 : 0);
            d  = timeout_mode ? c_TO - 1 : $urandom_range(5, 0);
            co = timeout_mode ? c_QNAN : $urandom;
            iss_q.push_back('{cyc + 1, p_op[w], p_a[w], p_b[w]});
            rsp_q.push_back('{cyc + 3 + d, w, co});
            m_op = p_op[w]; m_a = p_a[w]; m_b = p_b[w];
            m_last    = w;
            m_free    = cyc + 4 + d;
            m_wait_lo = cyc + 2;
            m_wait_hi = cyc + 2 + d;
            m_hold_lo = cyc + 1;
            m_hold_hi = cyc + 2 + d;
            m_fv_co   = co;
            if (timeout_mode) begin
                m_fv_cyc   = -1;
                m_terr_cyc = cyc + 3 + d;
            end else begin
                m_fv_cyc = cyc + 2 + d;
            end
            p_v[w] = 0;
            if (w == 1) exp1 = 1'b1; else exp0 = 1'b1;
        end
        chk("req0_ready", req0_ready, exp0);
        chk("req1_ready", req1_ready, exp1);
        chk("busy", busy, !idle);
        chk("timeout_err", timeout_err, cyc >= m_terr_cyc);
        if (cyc >= m_hold_lo && cyc <= m_hold_hi) begin
            chk("fpu_instruction_hold", fpu_instruction, m_op);
            chk("fpu_ai_hold", fpu_ai, m_a);
            chk("fpu_bi_hold", fpu_bi, m_b);
        end else if (idle) begin
            chk("fpu_ai_idle", fpu_ai, 32'h0);
            chk("fpu_bi_idle", fpu_bi, 32'h0);
            chk("fpu_instruction_idle", fpu_instruction, 2'b00);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an issue or a response
    initial begin : monitor
        issue_t it;
        rsp_t   rs;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                while (iss_q.size() > 0 && iss_q[0].cyc < cyc) begin
                    fail_msg($sformatf("missing_enable expected at cycle %0d", iss_q[0].cyc));
                    void'(iss_q.pop_front());
                end
                while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
                    fail_msg($sformatf("missing_rsp expected at cycle %0d data %h", rsp_q[0].cyc, rsp_q[0].data));
                    void'(rsp_q.pop_front());
                end
                if (fpu_enable) begin
                    if (iss_q.size() == 0) begin
                        fail_msg("unexpected fpu_enable: got 1 expected 0");
                    end else begin
                        it = iss_q.pop_front();
                        chk("enable_cycle", cyc, it.cyc);
                        chk("issue_op", fpu_instruction, it.op);
                        chk("issue_a", fpu_ai, it.a);
                        chk("issue_b", fpu_bi, it.b);
                    end
                end
                if (!rsp0_valid) chk("rsp0_data_hold", rsp0_data, last0);
                if (!rsp1_valid) chk("rsp1_data_hold", rsp1_data, last1);
                if (rsp0_valid || rsp1_valid) begin
                    if (rsp_q.size() == 0) begin
                        fail_msg($sformatf("unexpected_rsp: got valid=%b%b expected none", rsp1_valid, rsp0_valid));
                    end else begin
                        rs = rsp_q.pop_front();
                        chk("rsp_cycle", cyc, rs.cyc);
                        chk("rsp_owner", {rsp1_valid, rsp0_valid}, (rs.owner == 1) ? 2'b10 : 2'b01);
                        chk("rsp_data", (rs.owner == 1) ? rsp1_data : rsp0_data, rs.data);
                        if (rs.owner == 1) last1 = rs.data; else last0 = rs.data;
                    end
                end
            end
        end
    end

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_fpu_enable"}, fpu_enable, 1'b0);
        chk({tag, "_fpu_instruction"}, fpu_instruction, 2'b00);
        chk({tag, "_fpu_ai"}, fpu_ai, 32'h0);
        chk({tag, "_fpu_bi"}, fpu_bi, 32'h0);
        chk({tag, "_rsp_valid"}, {rsp1_valid, rsp0_valid}, 2'b00);
        chk({tag, "_rsp0_data"}, rsp0_data, 32'h0);
        chk({tag, "_rsp1_data"}, rsp1_data, 32'h0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_timeout_err"}, timeout_err, 1'b0);
        chk({tag, "_ready"}, {req1_ready, req0_ready}, 2'b00);
    endtask

    task automatic tie_after_reset();
        p_v[0] = 1; p_op[0] = 2'b10; p_a[0] = 32'h3F80_0000; p_b[0] = 32'h3F80_0000;
        p_v[1] = 1; p_op[1] = 2'b11; p_a[1] = 32'h4040_0000; p_b[1] = 32'h3F80_0000;
        step(1);
        chk("tie_req0_wins", {req1_ready, req0_ready}, 2'b01);
        for (int n = 0; n < 30 && p_v[1]; n++) step(1);
        if (p_v[1]) fail_msg("req1 not granted after req0: got pending expected granted");
    endtask

    task automatic drain();
        int n;
        en_mask[0] = 0; en_mask[1] = 0; p_v[0] = 0; p_v[1] = 0;
        n = 0;
        while ((cyc < m_free + 1 || iss_q.size() > 0 || rsp_q.size() > 0) && n < 60) begin
            step(0);
            n++;
        end
        if (n >= 60) fail_msg($sformatf("drain timeout: %0d issues %0d rsps outstanding expected 0", iss_q.size(), rsp_q.size()));
    endtask

    initial begin : stimulus
        int n;
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; req0_op = 0; req1_op = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        fpu_valid = 0; fpu_co = 0;
        spur_en = 0; timeout_mode = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_zero_outputs("reset");
        @(posedge clk);
        #2 rst = 1'b0;

        tie_after_reset();

        spur_en = 1;
        en_mask[0] = 1; en_mask[1] = 0;
        repeat (150) step(0);
        en_mask[1] = 1;
        repeat (600) step(0);

        // Async reset in the middle of a WAIT window
        n = 0;
        do begin
            step(0);
            n++;
        end while (!(cyc >= m_wait_lo && cyc <= m_wait_hi) && n < 200);
        if (n >= 200) fail_msg("no WAIT window reached for mid-op reset");
        #2;
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; fpu_valid = 0;
        #1;
        check_zero_outputs("midreset");
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        tie_after_reset();
        en_mask[0] = 1; en_mask[1] = 1;
        repeat (300) step(0);
        drain();

`ifdef FPU_ARB_TIMEOUT_EN
        timeout_mode = 1;
        p_v[0] = 1; p_op[0] = 2'b10; p_a[0] = 32'h3F80_0000; p_b[0] = 32'h4000_0000;
        step(1);
        timeout_mode = 0;
        en_mask[0] = 1; en_mask[1] = 1;
        repeat (30) step(0);
        chk("timeout_err_sticky", timeout_err, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
